// File: rtl/id_stage.sv
// ============================================================================
//  Module   : id_stage
//  Purpose  : RV32I decode stage with IF/ID and ID/EX registers, a 32x32
//             register file with write-through bypass, and load-use/flush control.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_pc_plus_4,
    input  logic [31:0] if_instr,
    input  logic        pc_src,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall_f,
    output logic        id_valid,
    output logic        id_illegal,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus_4,
    output logic [31:0] id_rs1_data,
    output logic [31:0] id_rs2_data,
    output logic [31:0] id_imm,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [2:0]  id_funct3,
    output logic [3:0]  id_alu_op,
    output logic        id_alu_src,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_reg_write,
    output logic        id_mem_to_reg,
    output logic        id_branch,
    output logic        id_jump
);

    localparam logic [6:0] c_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_LOAD   = 7'b0000011;
    localparam logic [6:0] c_STORE  = 7'b0100011;
    localparam logic [6:0] c_BRANCH = 7'b1100011;
    localparam logic [6:0] c_JAL    = 7'b1101111;
    localparam logic [6:0] c_JALR   = 7'b1100111;
    localparam logic [6:0] c_LUI    = 7'b0110111;
    localparam logic [6:0] c_AUIPC  = 7'b0010111;

    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc4;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;
    logic [31:0] r_rf [32];

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_illegal;
    logic        w_alu_src;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_has_rd;
    logic        w_branch;
    logic        w_jump;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic [31:0] w_imm;
    logic [3:0]  w_alu_op;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic        w_reg_write;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic        w_hazard;
    logic        w_issue;
    logic        w_trap;

    assign w_opcode = r_ifid_instr[6:0];
    assign w_funct3 = r_ifid_instr[14:12];

    always_comb begin
        w_illegal   = 1'b0;
        w_alu_src   = 1'b1;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_has_rd    = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_imm       = 32'd0;
        w_alu_op    = 4'd0;
        case (w_opcode)
            c_OP: begin
                w_alu_src = 1'b0;
                w_has_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_alu_op  = {r_ifid_instr[30], w_funct3};
            end
            c_OP_IMM: begin
                w_has_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_imm     = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
                w_alu_op  = (w_funct3 == 3'b101) ? {r_ifid_instr[30], w_funct3}
                                                 : {1'b0, w_funct3};
            end
            c_LOAD: begin
                w_mem_read = 1'b1;
                w_has_rd   = 1'b1;
                w_use_rs1  = 1'b1;
                w_imm      = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
            end
            c_STORE: begin
                w_mem_write = 1'b1;
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_imm       = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:25],
                               r_ifid_instr[11:7]};
            end
            c_BRANCH: begin
                w_alu_src = 1'b0;
                w_branch  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm     = {{19{r_ifid_instr[31]}}, r_ifid_instr[31], r_ifid_instr[7],
                             r_ifid_instr[30:25], r_ifid_instr[11:8], 1'b0};
            end
            c_JAL: begin
                w_jump   = 1'b1;
                w_has_rd = 1'b1;
                w_imm    = {{11{r_ifid_instr[31]}}, r_ifid_instr[31], r_ifid_instr[19:12],
                            r_ifid_instr[20], r_ifid_instr[30:21], 1'b0};
            end
            c_JALR: begin
                w_jump    = 1'b1;
                w_has_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_imm     = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
            end
            c_LUI, c_AUIPC: begin
                w_has_rd = 1'b1;
                w_imm    = {r_ifid_instr[31:12], 12'd0};
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Unused source fields read as x0 so they can never match a load destination.
    assign w_rs1       = w_use_rs1 ? r_ifid_instr[19:15] : 5'd0;
    assign w_rs2       = w_use_rs2 ? r_ifid_instr[24:20] : 5'd0;
    assign w_rd        = w_has_rd  ? r_ifid_instr[11:7]  : 5'd0;
    assign w_reg_write = w_has_rd & (w_rd != 5'd0);

    assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 :
                        (wb_we && (wb_rd == w_rs1)) ? wb_data : r_rf[w_rs1];
    assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 :
                        (wb_we && (wb_rd == w_rs2)) ? wb_data : r_rf[w_rs2];

    assign w_hazard = id_valid & id_mem_read & (id_rd != 5'd0) & r_ifid_valid &
                      ((w_rs1 == id_rd) | (w_rs2 == id_rd));
    assign stall_f  = w_hazard & ~pc_src;
    assign w_issue  = r_ifid_valid & ~w_illegal & ~pc_src & ~w_hazard;
    assign w_trap   = r_ifid_valid & w_illegal & ~pc_src;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
        end else if (wb_we && (wb_rd != 5'd0)) begin
            r_rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || pc_src) begin
            r_ifid_pc    <= 32'd0;
            r_ifid_pc4   <= 32'd0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (!w_hazard) begin
            r_ifid_pc    <= if_pc;
            r_ifid_pc4   <= if_pc_plus_4;
            r_ifid_instr <= if_instr;
            r_ifid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || !w_issue) begin
            id_valid      <= 1'b0;
            id_illegal    <= reset ? 1'b0 : w_trap;
            id_pc         <= 32'd0;
            id_pc_plus_4  <= 32'd0;
            id_rs1_data   <= 32'd0;
            id_rs2_data   <= 32'd0;
            id_imm        <= 32'd0;
            id_rs1        <= 5'd0;
            id_rs2        <= 5'd0;
            id_rd         <= 5'd0;
            id_funct3     <= 3'd0;
            id_alu_op     <= 4'd0;
            id_alu_src    <= 1'b0;
            id_mem_read   <= 1'b0;
            id_mem_write  <= 1'b0;
            id_reg_write  <= 1'b0;
            id_mem_to_reg <= 1'b0;
            id_branch     <= 1'b0;
            id_jump       <= 1'b0;
        end else begin
            id_valid      <= 1'b1;
            id_illegal    <= 1'b0;
            id_pc         <= r_ifid_pc;
            id_pc_plus_4  <= r_ifid_pc4;
            id_rs1_data   <= w_rs1_data;
            id_rs2_data   <= w_rs2_data;
            id_imm        <= w_imm;
            id_rs1        <= w_rs1;
            id_rs2        <= w_rs2;
            id_rd         <= w_rd;
            id_funct3     <= w_funct3;
            id_alu_op     <= w_alu_op;
            id_alu_src    <= w_alu_src;
            id_mem_read   <= w_mem_read;
            id_mem_write  <= w_mem_write;
            id_reg_write  <= w_reg_write;
            id_mem_to_reg <= w_mem_read;
            id_branch     <= w_branch;
            id_jump       <= w_jump;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// ============================================================================
//  Module   : tb_id_stage
//  Purpose  : Directed self-checking bench for id_stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc, if_pc_plus_4, if_instr;
    logic        pc_src, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_f, id_valid, id_illegal;
    logic [31:0] id_pc, id_pc_plus_4, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write;
    logic        id_mem_to_reg, id_branch, id_jump;

    int n_cmp = 0;
    int n_err = 0;

    id_stage dut (
        .clk(clk), .reset(reset),
        .if_pc(if_pc), .if_pc_plus_4(if_pc_plus_4), .if_instr(if_instr),
        .pc_src(pc_src), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_f(stall_f), .id_valid(id_valid), .id_illegal(id_illegal),
        .id_pc(id_pc), .id_pc_plus_4(id_pc_plus_4),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .id_jump(id_jump)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
        if_instr     = instr;
        if_pc        = pc;
        if_pc_plus_4 = pc + 32'd4;
        step();
    endtask

    localparam logic [31:0] ADDI   = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] ADD43  = 32'h00018233;  // add  x4,x3,x0
    localparam logic [31:0] ADD700 = 32'h000003B3;  // add  x7,x0,x0
    localparam logic [31:0] SRAI   = 32'h4030D093;  // srai x1,x1,3
    localparam logic [31:0] LW     = 32'h00012283;  // lw   x5,0(x2)
    localparam logic [31:0] ADD651 = 32'h00128333;  // add  x6,x5,x1
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] BEQ    = 32'hFE208CE3;  // beq  x1,x2,-8
    localparam logic [31:0] LUI    = 32'h12345137;  // lui  x2,0x12345

    initial begin
        reset = 1'b1; pc_src = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        if_instr = NOP; if_pc = 32'd0; if_pc_plus_4 = 32'd4;
        #1;
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_stall", {31'd0, stall_f}, 32'd0);
        step(); step();
        check("rst_imm", id_imm, 32'd0);
        reset = 1'b0;

        // addi: appears two edges after presentation
        fetch(ADDI, 32'h100);
        fetch(NOP, 32'h104);
        check("addi_rd", {27'd0, id_rd}, 32'd1);
        check("addi_imm", id_imm, 32'd5);
        check("addi_src", {31'd0, id_alu_src}, 32'd1);
        check("addi_rw", {31'd0, id_reg_write}, 32'd1);
        check("addi_valid", {31'd0, id_valid}, 32'd1);
        check("addi_pc", id_pc, 32'h100);

        // write-through bypass while add x4,x3,x0 sits in IF/ID
        fetch(ADD43, 32'h108);
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        fetch(ADD700, 32'h10C);
        check("byp_rs1", id_rs1_data, 32'hDEADBEEF);
        check("byp_rd", {27'd0, id_rd}, 32'd4);
        check("byp_src", {31'd0, id_alu_src}, 32'd0);
        // add x7 in IF/ID while x0 is written
        wb_rd = 5'd0; wb_data = 32'h12345678;
        fetch(ADD43, 32'h110);
        check("x0_rs1", id_rs1_data, 32'd0);
        check("x0_rs2", id_rs2_data, 32'd0);
        wb_we = 1'b0;
        fetch(SRAI, 32'h114);
        check("rf_stored", id_rs1_data, 32'hDEADBEEF);
        fetch(NOP, 32'h118);
        check("srai_op", {28'd0, id_alu_op}, 32'hD);
        check("srai_imm", id_imm, 32'h403);

        // load-use: one stall, one bubble, then the add
        fetch(LW, 32'h200);
        fetch(ADD651, 32'h204);
        check("lu_mr", {31'd0, id_mem_read}, 32'd1);
        check("lu_m2r", {31'd0, id_mem_to_reg}, 32'd1);
        check("lu_stall", {31'd0, stall_f}, 32'd1);
        fetch(NOP, 32'h208);
        check("lu_bub_v", {31'd0, id_valid}, 32'd0);
        check("lu_bub_rw", {31'd0, id_reg_write}, 32'd0);
        check("lu_stall_off", {31'd0, stall_f}, 32'd0);
        fetch(NOP, 32'h208);
        check("lu_add_v", {31'd0, id_valid}, 32'd1);
        check("lu_add_rs1", {27'd0, id_rs1}, 32'd5);
        check("lu_add_rd", {27'd0, id_rd}, 32'd6);

        // flush concurrent with a load-use hazard
        fetch(LW, 32'h300);
        fetch(ADD651, 32'h304);
        pc_src = 1'b1;
        #1;
        check("fl_stall", {31'd0, stall_f}, 32'd0);
        fetch(NOP, 32'h400);
        pc_src = 1'b0;
        check("fl_v1", {31'd0, id_valid}, 32'd0);
        check("fl_rw1", {31'd0, id_reg_write}, 32'd0);
        fetch(NOP, 32'h404);
        check("fl_v2", {31'd0, id_valid}, 32'd0);
        check("fl_rw2", {31'd0, id_reg_write}, 32'd0);

        // illegal opcode, then a backward branch, then lui
        fetch(32'hFFFFFFFF, 32'h500);
        fetch(BEQ, 32'h504);
        check("ill_flag", {31'd0, id_illegal}, 32'd1);
        check("ill_valid", {31'd0, id_valid}, 32'd0);
        fetch(LUI, 32'h508);
        check("ill_clear", {31'd0, id_illegal}, 32'd0);
        check("beq_imm", id_imm, 32'hFFFFFFF8);
        check("beq_br", {31'd0, id_branch}, 32'd1);
        check("beq_rw", {31'd0, id_reg_write}, 32'd0);
        check("beq_rs2", {27'd0, id_rs2}, 32'd2);
        fetch(NOP, 32'h50C);
        check("lui_imm", id_imm, 32'h12345000);
        check("lui_rs1", {27'd0, id_rs1}, 32'd0);

        // reset while stalled
        fetch(LW, 32'h600);
        fetch(ADD651, 32'h604);
        check("rs_pre_stall", {31'd0, stall_f}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rs_stall", {31'd0, stall_f}, 32'd0);
        check("rs_valid", {31'd0, id_valid}, 32'd0);
        check("rs_mr", {31'd0, id_mem_read}, 32'd0);
        check("rs_rd", {27'd0, id_rd}, 32'd0);
        step();
        reset = 1'b0;
        fetch(ADD43, 32'h700);
        fetch(NOP, 32'h704);
        check("rs_rec_v", {31'd0, id_valid}, 32'd1);
        check("rs_rec_pc", id_pc, 32'h700);
        check("rs_rf_clr", id_rs1_data, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter NOP_INSTR, default 32'h00000013, instruction word loaded into IF/ID on flush.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 if_pc / if_pc_plus_4 / if_instr  input  32 each  fetch-stage outputs.
REQ-005 pc_src  input  1  branch/jump taken in EX; flush request.
REQ-006 wb_we  input  1; wb_rd  input  5; wb_data  input  32  register-file write port.
REQ-007 stall_f  output  1  fetch hold request (combinational).
REQ-008 id_valid, id_illegal  output  1 each  ID/EX slot holds real instruction / unknown opcode seen.
REQ-009 id_pc, id_pc_plus_4, id_rs1_data, id_rs2_data, id_imm  output  32 each.
REQ-010 id_rs1, id_rs2, id_rd  output  5 each; id_funct3  output  3; id_alu_op  output  4.
REQ-011 id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch, id_jump  output  1 each.

Function
REQ-012 IF/ID register (pc, pc_plus_4, instr, valid) SHALL load if_* with valid=1 each posedge unless stalled or flushed.
REQ-013 Decode SHALL be combinational from IF/ID; all id_* outputs SHALL be registered (ID/EX); latency: if_instr sampled at edge k appears on id_* after edge k+1.
REQ-014 Opcodes decoded: OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111; any other opcode with valid IF/ID SHALL produce a bubble with id_illegal=1 for one cycle.
REQ-015 Immediates SHALL be sign-extended to 32 bits per RV32I I/S/B/U/J formats (B, J bit0=0; U low 12 bits zero); R-type id_imm=0.
REQ-016 id_alu_op = {instr[30], funct3} for OP and for OP-IMM with funct3=101; {1'b0, funct3} for other OP-IMM; 4'b0000 for all other opcodes.
REQ-017 id_alu_src=1 for all formats except OP and BRANCH; id_mem_to_reg=id_mem_read=1 for LOAD; id_reg_write=1 for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC with rd!=0.
REQ-018 rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR; rs2 by OP, STORE, BRANCH; unused rs fields SHALL be output as 0.
REQ-019 Register file: 32x32; x0 reads 0; writes to x0 ignored; write on posedge when wb_we=1; same-cycle read of wb_rd (nonzero, wb_we=1) SHALL return wb_data (write-through bypass).
REQ-020 Load-use hazard = id_valid & id_mem_read & id_rd!=0 & IF/ID valid & (used rs1==id_rd or used rs2==id_rd).
REQ-021 On hazard with pc_src=0: stall_f=1, IF/ID holds, ID/EX loads bubble (id_valid=0, all control and id_illegal 0); exactly one bubble per load-use pair.
REQ-022 On pc_src=1: IF/ID loads NOP_INSTR with valid=0, ID/EX loads bubble, stall_f=0; flush SHALL override hazard.
REQ-023 Bubble/invalid slot SHALL never assert id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump.

Reset
REQ-024 On reset assertion, immediately: IF/ID valid=0, instr=NOP_INSTR, pc fields 0; every id_* output 0; all 32 registers 0; stall_f=0.
REQ-025 Reset mid-stall or mid-flush SHALL discard pending state; first post-reset edge loads IF/ID normally.

Verification
REQ-026 if_instr=32'h00500093 (addi x1,x0,5) -> two edges later id_rd=1, id_imm=5, id_alu_src=1, id_reg_write=1, id_valid=1.
REQ-027 wb_we=1, wb_rd=3, wb_data=32'hDEADBEEF while IF/ID holds add x4,x3,x0 -> id_rs1_data=32'hDEADBEEF next edge; write to x0 -> reads remain 0.
REQ-028 lw x5,0(x2) then add x6,x5,x1 -> stall_f=1 one cycle, one bubble, add issues next cycle with id_rs1=5.
REQ-029 pc_src=1 concurrent with load-use hazard -> stall_f=0, id_valid=0 for two consecutive cycles, no id_reg_write.
REQ-030 if_instr=32'hFFFFFFFF -> id_illegal=1, id_valid=0 one cycle; beq imm -8 -> id_imm=32'hFFFFFFF8, id_branch=1.
REQ-031 Assert reset during stall -> all outputs 0 asynchronously, stall_f=0, recovery on first edge after release.
